mux_scan: RTL
=============

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data channel.
REQ-002 Parameter NCH, default 4, number of input channels (2..16).
REQ-003 Parameter SELW, default 2, select width; SHALL satisfy 2**SELW >= NCH.
REQ-004 Parameter DWELL, default 4, clock cycles spent on each channel in scan mode (1..255).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous reset, active-high.
REQ-007 en  input  1  enables sampling; when low, all outputs hold.
REQ-008 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 sel  input  SELW  channel index used in manual mode.
REQ-010 din  input  NCH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 dout  output  WIDTH  registered selected data.
REQ-012 cur_sel  output  SELW  index of the channel currently driving dout.
REQ-013 valid  output  1  high for exactly one cycle after each dout update.
REQ-014 err  output  1  registered flag, high while the last manual sel was >= NCH.

Function
REQ-015 States: IDLE, MAN, SCAN; state register SHALL be 2 bits wide.
REQ-016 IDLE->MAN when en=1 and mode=0; IDLE->SCAN when en=1 and mode=1; any state->IDLE when en=0.
REQ-017 MAN<->SCAN SHALL switch on the first clock edge after mode changes; the dwell counter SHALL clear on every switch.
REQ-018 MAN: each cycle, cur_sel<=sel and dout<=channel sel; latency from sel/din to dout is exactly 1 cycle; valid=1.
REQ-019 MAN with sel>=NCH: dout<=0, cur_sel<=sel, err<=1, valid=1; err SHALL clear on the next in-range sample.
REQ-020 SCAN entry: cur_sel<=0, dwell counter<=0; dout<=channel 0 in the same edge; valid=1.
REQ-021 SCAN: dout SHALL track din of cur_sel every cycle; valid SHALL pulse only on the cycle after cur_sel advances (and on entry).
REQ-022 Dwell counter SHALL count 0..DWELL-1; at DWELL-1 it SHALL wrap to 0 and advance cur_sel.
REQ-023 cur_sel SHALL wrap from NCH-1 to 0; values >= NCH SHALL never occur in SCAN; err SHALL be 0 in SCAN.
REQ-024 IDLE: dout, cur_sel, err hold; valid=0; the dwell counter holds and resumes after return to SCAN only if mode was unchanged.
REQ-025 DWELL=1: cur_sel SHALL advance every cycle and valid SHALL stay high continuously.

Reset
REQ-026 rst=1 at a clock edge SHALL force state=IDLE, dout=0, cur_sel=0, err=0, valid=0, dwell counter=0, overriding en and mode.
REQ-027 Reset asserted mid-scan SHALL abandon the dwell count; the first SCAN after reset SHALL start at channel 0.
REQ-028 No output SHALL change between clock edges (no combinational input-to-output path).

Configuration
REQ-029 Macro MUX_SCAN_PARITY_EN: when defined, an output par (1 bit) SHALL equal XOR-reduction of the dout value, registered on the same edge as dout and reset to 0.
REQ-030 Without MUX_SCAN_PARITY_EN, the par port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 WIDTH=8, NCH=4, mode=0, en=1, din={8'hD3,8'hC2,8'hB1,8'hA0}, sel=2 -> next cycle dout=8'hC2, cur_sel=2, valid=1, err=0.
REQ-032 NCH=3, SELW=2, mode=0, sel=3 -> dout=0, err=1; then sel=1 -> err=0, dout=channel 1.
REQ-033 mode=1, DWELL=4, NCH=4 -> cur_sel sequence 0,0,0,0,1,1,1,1,2,...,3,3,3,3,0; valid pulses every 4 cycles.
REQ-034 In SCAN at cur_sel=2, drop en for 3 cycles -> outputs frozen, valid=0; raise en -> cur_sel continues with remaining dwell.
REQ-035 rst=1 during SCAN at cur_sel=3 -> next edge all outputs 0; release with mode=1 -> scan restarts at channel 0.
REQ-036 MUX_SCAN_PARITY_EN defined, dout=8'hC2 -> par=1; dout=8'hA0 -> par=0.

Source files
------------

// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select and timed auto-scan modes.
// Optional MUX_SCAN_PARITY_EN adds a registered even-parity output 'par' for dout.
module mux_scan #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      cur_sel,
  output logic                 valid,
  output logic                 err
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                 par
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAN  = 2'd1,
    SCAN = 2'd2
  } state_t;

  localparam logic [7:0]      CNT_LAST = 8'(DWELL - 1);
  localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0] curSel_q, curSel_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            resume_q, resume_d;
  logic            selInRange;

  // Unused select codes (>= NCH) return zero.
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] s,
                                            input logic [NCH*WIDTH-1:0] d);
    logic [WIDTH-1:0] result;
    result = '0;
    for (int k = 0; k < NCH; k++) begin
      if (s == SELW'(k)) result = d[k*WIDTH +: WIDTH];
    end
    return result;
  endfunction

  assign selInRange = (32'(sel) < 32'(NCH));

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    curSel_d = curSel_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    resume_d = resume_q;

    if (!en) begin
      state_d = IDLE;
    end else if (!mode) begin
      state_d  = MAN;
      resume_d = 1'b0;
      cnt_d    = '0;
      curSel_d = sel;
      dout_d   = pick(sel, din);
      err_d    = !selInRange;
      valid_d  = 1'b1;
    end else begin
      state_d  = SCAN;
      resume_d = 1'b1;
      err_d    = 1'b0;
      // A pause in IDLE keeps the dwell position only if scanning was the last active mode.
      if (state_q == SCAN || (state_q == IDLE && resume_q)) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          curSel_d = (curSel_q == SEL_LAST) ? '0 : SELW'(curSel_q + 1'b1);
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d    = '0;
        curSel_d = '0;
        valid_d  = 1'b1;
      end
      dout_d = pick(curSel_d, din);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      curSel_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dout_q   <= dout_d;
      curSel_q <= curSel_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      resume_q <= resume_d;
    end
  end

  assign dout    = dout_q;
  assign cur_sel = curSel_q;
  assign valid   = valid_q;
  assign err     = err_q;

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= ^dout_d;
  end

  assign par = par_q;
`endif

endmodule
